shift_add_mult_8: RTL
=====================

# shift_add_mult_8

Sequential 8×8 unsigned shift-and-add multiplier built around the existing `rca_8` ripple-carry adder. It owns the operand registers and control that feed `rca_8` each cycle, and consumes its `sum`/`cout` to form a 16-bit product. A start/busy/done handshake connects it to the surrounding datapath.

## Interface
- Parameters: none. Width is fixed at 8 by `rca_8`.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, sampled on `clk`.
- `start`  in  1  request a multiply; accepted only in IDLE.
- `a`  in  8  multiplicand, unsigned; sampled only on the accepting edge.
- `b`  in  8  multiplier, unsigned; sampled only on the accepting edge.
- `product`  out  16  result register, valid while `done`=1 and held until the next accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  single-cycle pulse, high while in DONE.

## Operation
- Registers:
  - `mcand[7:0]`
  - `P[15:0]`, which is also `product`
  - `cnt[2:0]`
  - `state`
- States:
  - IDLE → RUN on `start`=1. At that edge: `mcand`←`a`, `P`←{8'h00, `b`}, `cnt`←0.
  - RUN, one step per edge:
    - `rca_8` inputs: A=`P[15:8]`, B=`P[0]` ? `mcand` : 8'h00, Cin=0.
    - `P`←{`cout`, `sum`, `P[7:1]`}.
    - `cnt`←`cnt`+1.
    - On the step where `cnt`==7, go to DONE.
  - DONE → IDLE unconditionally on the next edge. `start` is ignored in DONE.
- `busy` = (state==RUN). `done` = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- Width rules:
  - The adder carry out is the new MSB after the shift, so no bit is lost.
  - The final `P` equals `a`·`b` for all 65 536 operand pairs.
- `start` in RUN or DONE is ignored and does not queue. Changes on `a`/`b` outside the accepting edge have no effect.
- If `start` is held high, the next operation is accepted on the first edge in IDLE, one cycle after `done`.
- Reset values on an edge with `rst`=1, taking priority over everything including `start`:
  - state=IDLE, `P`=0, `mcand`=0, `cnt`=0.
  - `product`=16'h0000, `busy`=0, `done`=0.
  - This applies mid-RUN as well: the operation is aborted and no `done` is produced.

## Timing
- Name the start-accept edge E0.
  - E1..E8 perform the 8 add-shift steps.
  - After E8: `done`=1 and `product` is final. `busy` is high after E0 through E7, i.e. 8 cycles.
  - After E9: `done`=0, state=IDLE.
- Latency from the accepting edge to `done` is 8 cycles. Throughput is one multiply per 10 cycles with `start` held high.
- Critical path is one `rca_8` carry chain, 8 full-adders, plus the B-operand mux.

## Structure
- Shared header/package holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - the constant STEPS=8
- Single sub-module: one instance of `rca_8`, with ports A, B, Cin, sum, cout. No second adder.
- The control FSM and datapath live in one file.

## Test plan
- `a`=8'hFF, `b`=8'hFF, pulse `start` → `busy` high for 8 cycles; `done` pulses once, 8 cycles after E0, with `product`=16'hFE01.
- `a`=8'd13, `b`=8'd11 → `product`=16'h008F. Change `a`/`b` to 8'h00 during RUN → result unchanged.
- `a`=8'h00, `b`=8'h5A → `product`=16'h0000. Then `a`=8'h5A, `b`=8'h00 → 16'h0000. Both finish in 8 cycles.
- Pulse `start` again during RUN and during DONE → ignored: exactly one `done`, and the result matches the first operands.
- Assert `rst` for one cycle at step 4 of `a`=8'h80, `b`=8'h03 → after that edge `product`=0, `busy`=0, `done`=0, and no `done` follows. A fresh start with 8'h80×8'h03 gives 16'h0180.
- Exhaustive run: loop i over 0..65535 with {`a`,`b`}=i, holding `start` high. On each `done`, compare `product` against golden `a`*`b` and display the failing i on mismatch. Expect zero failures and one result every 10 cycles.

Source files
------------

// File: rtl/shift_add_mult_8_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift_add_mult_8_pkg : state encodings and step count for shift_add_mult_8
// Rev 1.0
// ----------------------------------------------------------------------------
package shift_add_mult_8_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int         STEPS    = 8;
  localparam logic [2:0] CNT_LAST = 3'(STEPS - 1);

endpackage : shift_add_mult_8_pkg
`default_nettype wire

// File: rtl/rca_8.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rca_8 : 8-bit ripple-carry adder, sum = A + B + Cin
// Rev 1.0
// ----------------------------------------------------------------------------
module rca_8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic w_carry;

  // Carry is a single variable rippled through the loop, one full adder per bit.
  always_comb begin
    sum     = '0;
    w_carry = Cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]  = A[i] ^ B[i] ^ w_carry;
      w_carry = (A[i] & B[i]) | (w_carry & (A[i] ^ B[i]));
    end
    cout = w_carry;
  end

endmodule : rca_8
`default_nettype wire

// File: rtl/shift_add_mult_8.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift_add_mult_8 : sequential 8x8 unsigned shift-and-add multiplier on rca_8
// Rev 1.0
// ----------------------------------------------------------------------------
module shift_add_mult_8
  import shift_add_mult_8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        busy,
  output logic        done
);

  logic [1:0]  state_q, state_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [15:0] p_q, p_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [7:0]  w_add_b;
  logic [7:0]  w_sum;
  logic        w_cout;

  assign w_add_b = p_q[0] ? mcand_q : 8'h00;

  rca_8 u_rca (
    .A    (p_q[15:8]),
    .B    (w_add_b),
    .Cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mcand_d = a;
          p_d     = {8'h00, b};
          cnt_d   = 3'd0;
        end
      end
      ST_RUN: begin
        // Carry-out becomes the new MSB, so the shift never drops a product bit.
        p_d   = {w_cout, w_sum, p_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mcand_q <= 8'h00;
      p_q     <= 16'h0000;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  assign product = p_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule : shift_add_mult_8
`default_nettype wire
